// File: rtl/pl_reg_elastic_pkg.sv
// Shared definitions for the elastic pipeline stages: thread-id sizing and
// the D/E payload bundle layout with pack/unpack helpers.
package pl_pkg;

  function automatic int bits_threads(input int num_threads);
    return (num_threads <= 2) ? 1 : $clog2(num_threads);
  endfunction

  localparam int W_REG_WRITE   = 1;
  localparam int W_RES_SRC     = 2;
  localparam int W_MEM_WRITE   = 1;
  localparam int W_JUMP        = 1;
  localparam int W_BRANCH      = 1;
  localparam int W_ALU_CONTROL = 4;
  localparam int W_FUNCT3      = 3;
  localparam int W_ALU_SRC_A   = 1;
  localparam int W_ALU_SRC_B   = 1;
  localparam int W_RD1         = 32;
  localparam int W_RD2         = 32;
  localparam int W_PC          = 32;
  localparam int W_RD          = 5;
  localparam int W_IMM_VAL     = 32;
  localparam int W_PC_PLUS4    = 32;

  // Offsets are LSB positions; pc_plus4 sits at bit 0, reg_write at the top.
  localparam int OFF_PC_PLUS4    = 0;
  localparam int OFF_IMM_VAL     = OFF_PC_PLUS4 + W_PC_PLUS4;
  localparam int OFF_RD          = OFF_IMM_VAL + W_IMM_VAL;
  localparam int OFF_PC          = OFF_RD + W_RD;
  localparam int OFF_RD2         = OFF_PC + W_PC;
  localparam int OFF_RD1         = OFF_RD2 + W_RD2;
  localparam int OFF_ALU_SRC_B   = OFF_RD1 + W_RD1;
  localparam int OFF_ALU_SRC_A   = OFF_ALU_SRC_B + W_ALU_SRC_B;
  localparam int OFF_FUNCT3      = OFF_ALU_SRC_A + W_ALU_SRC_A;
  localparam int OFF_ALU_CONTROL = OFF_FUNCT3 + W_FUNCT3;
  localparam int OFF_BRANCH      = OFF_ALU_CONTROL + W_ALU_CONTROL;
  localparam int OFF_JUMP        = OFF_BRANCH + W_BRANCH;
  localparam int OFF_MEM_WRITE   = OFF_JUMP + W_JUMP;
  localparam int OFF_RES_SRC     = OFF_MEM_WRITE + W_MEM_WRITE;
  localparam int OFF_REG_WRITE   = OFF_RES_SRC + W_RES_SRC;
  localparam int DE_WIDTH        = OFF_REG_WRITE + W_REG_WRITE;

  typedef struct packed {
    logic                     reg_write;
    logic [W_RES_SRC-1:0]     res_src;
    logic                     mem_write;
    logic                     jump;
    logic                     branch;
    logic [W_ALU_CONTROL-1:0] alu_control;
    logic [W_FUNCT3-1:0]      funct3;
    logic                     alu_src_a;
    logic                     alu_src_b;
    logic [W_RD1-1:0]         rd1;
    logic [W_RD2-1:0]         rd2;
    logic [W_PC-1:0]          pc;
    logic [W_RD-1:0]          rd;
    logic [W_IMM_VAL-1:0]     imm_val;
    logic [W_PC_PLUS4-1:0]    pc_plus4;
  } de_bundle_t;

  function automatic logic [DE_WIDTH-1:0] pack_de(input de_bundle_t b);
    return b;
  endfunction

  function automatic de_bundle_t unpack_de(input logic [DE_WIDTH-1:0] v);
    return de_bundle_t'(v);
  endfunction

endpackage

// File: rtl/pl_reg_elastic_sat_counter.sv
// Saturating up-counter, increments by 0..3 per cycle, synchronous clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH+1:0] sum;

  assign sum = {2'b00, count_q} + {{WIDTH{1'b0}}, inc_i};

  always_comb begin
    count_d = sum[WIDTH-1:0];
    if (|sum[WIDTH+1:WIDTH]) count_d = '1;
  end

  always_ff @(posedge clk) begin
    if (clr) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pl_reg_elastic.sv
// Elastic pipeline register: main + skid slot, registered in_ready,
// per-thread kill of in-flight beats, saturating count of discarded beats.
module pl_reg_elastic
  import pl_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 180,
  parameter int NUM_THREADS   = 8,
  parameter int BITS_THREADS  = bits_threads(NUM_THREADS),
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  input  logic [BITS_THREADS-1:0]  in_tid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic [BITS_THREADS-1:0]  out_tid,
  input  logic [NUM_THREADS-1:0]   kill_mask,
  output logic [1:0]               occupancy,
  output logic [CNT_WIDTH-1:0]     kill_count
);

  localparam int TID_SPACE = 1 << BITS_THREADS;

  logic                     main_valid_q, main_valid_d;
  logic [BITS_THREADS-1:0]  main_tid_q, main_tid_d;
  logic [PAYLOAD_WIDTH-1:0] main_payload_q, main_payload_d;
  logic                     skid_valid_q, skid_valid_d;
  logic [BITS_THREADS-1:0]  skid_tid_q, skid_tid_d;
  logic [PAYLOAD_WIDTH-1:0] skid_payload_q, skid_payload_d;
  logic                     in_ready_q;

  logic [TID_SPACE-1:0] kill_ext;
  logic accept, emit, main_kill, skid_kill, in_kill;
  logic main_stay, skid_live, in_store;
  logic [1:0] kill_inc;

  // Widen the mask so any tid value indexes in range (NUM_THREADS=1 case).
  always_comb begin
    kill_ext = '0;
    kill_ext[NUM_THREADS-1:0] = kill_mask;
  end

  assign in_ready  = in_ready_q & ~clr;
  assign out_valid = main_valid_q & ~kill_ext[main_tid_q];
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign main_kill = main_valid_q & kill_ext[main_tid_q];
  assign skid_kill = skid_valid_q & kill_ext[skid_tid_q];
  assign in_kill   = accept & kill_ext[in_tid];
  assign main_stay = out_valid & ~out_ready;
  assign skid_live = skid_valid_q & ~skid_kill;
  assign in_store  = accept & ~in_kill;

  always_comb begin
    main_valid_d   = main_valid_q;
    main_tid_d     = main_tid_q;
    main_payload_d = main_payload_q;
    skid_valid_d   = skid_valid_q;
    skid_tid_d     = skid_tid_q;
    skid_payload_d = skid_payload_q;
    if (!main_stay) begin
      skid_valid_d = 1'b0;
      if (skid_live) begin
        main_valid_d   = 1'b1;
        main_tid_d     = skid_tid_q;
        main_payload_d = skid_payload_q;
      end else if (in_store) begin
        main_valid_d   = 1'b1;
        main_tid_d     = in_tid;
        main_payload_d = in_payload;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (skid_live) begin
      skid_valid_d = 1'b1;
    end else if (in_store) begin
      skid_valid_d   = 1'b1;
      skid_tid_d     = in_tid;
      skid_payload_d = in_payload;
    end else begin
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      main_valid_q   <= 1'b0;
      main_tid_q     <= '0;
      main_payload_q <= '0;
      skid_valid_q   <= 1'b0;
      skid_tid_q     <= '0;
      skid_payload_q <= '0;
      in_ready_q     <= 1'b1;
    end else begin
      main_valid_q   <= main_valid_d;
      main_tid_q     <= main_tid_d;
      main_payload_q <= main_payload_d;
      skid_valid_q   <= skid_valid_d;
      skid_tid_q     <= skid_tid_d;
      skid_payload_q <= skid_payload_d;
      in_ready_q     <= ~skid_valid_d;
    end
  end

  assign kill_inc = {1'b0, main_kill} + {1'b0, skid_kill} + {1'b0, in_kill};

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_kill_cnt (
    .clk    (clk),
    .clr    (clr),
    .inc_i  (kill_inc),
    .count_o(kill_count)
  );

  assign out_payload = main_payload_q;
  assign out_tid     = main_tid_q;
  assign occupancy   = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pl_reg_elastic.sv
// Scoreboard bench for pl_reg_elastic: reference queue of live beats,
// emit monitor decoupled from the stimulus driver.
module tb_pl_reg_elastic;

  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          clr;
  logic          in_valid, in_ready;
  logic [PW-1:0] in_payload;
  logic [2:0]    in_tid;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_payload;
  logic [2:0]    out_tid;
  logic [7:0]    kill_mask;
  logic [1:0]    occupancy;
  logic [15:0]   kill_count;

  logic          s_in_ready, s_out_valid;
  logic [PW-1:0] s_out_payload;
  logic [2:0]    s_out_tid;
  logic [1:0]    s_occupancy;
  logic [1:0]    s_kill_count;

  always #5 clk = ~clk;

  pl_reg_elastic #(.PAYLOAD_WIDTH(PW), .NUM_THREADS(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_tid(in_tid), .out_valid(out_valid),
    .out_ready(out_ready), .out_payload(out_payload), .out_tid(out_tid),
    .kill_mask(kill_mask), .occupancy(occupancy), .kill_count(kill_count)
  );

  pl_reg_elastic #(.PAYLOAD_WIDTH(PW), .NUM_THREADS(8), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_payload(in_payload), .in_tid(in_tid), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_payload(s_out_payload), .out_tid(s_out_tid),
    .kill_mask(kill_mask), .occupancy(s_occupancy), .kill_count(s_kill_count)
  );

  typedef struct {
    logic [2:0]    tid;
    logic [PW-1:0] p;
  } beat_t;

  beat_t exp_q[$];
  int    kcnt = 0;
  int    total = 0;
  int    bad = 0;
  logic  started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: whatever the DUT presents must be the oldest live beat.
  always @(negedge clk) begin
    #2;
    if (started) begin
      chk("out_valid", out_valid,
          (exp_q.size() > 0) && !kill_mask[exp_q[0].tid]);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("emit_without_beat", 1'b1, 1'b0);
        end else begin
          chk("out_payload", out_payload, exp_q[0].p);
          chk("out_tid", out_tid, exp_q[0].tid);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic v, input logic [PW-1:0] p, input logic [2:0] t,
                      input logic ordy, input logic [7:0] km, input logic c,
                      output logic acc);
    longint k16, k2;
    @(negedge clk);
    in_valid = v; in_payload = p; in_tid = t;
    out_ready = ordy; kill_mask = km; clr = c;
    acc = v && !c && (exp_q.size() < 2);
    @(posedge clk);
    #1;
    if (c) begin
      exp_q.delete();
      kcnt = 0;
    end else begin
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (km[exp_q[i].tid]) begin
          exp_q.delete(i);
          kcnt++;
        end
      if (acc) begin
        if (km[t]) kcnt++;
        else exp_q.push_back('{tid: t, p: p});
      end
    end
    k16 = (kcnt > 65535) ? 65535 : kcnt;
    k2  = (kcnt > 3) ? 3 : kcnt;
    chk("occupancy", occupancy, exp_q.size());
    chk("in_ready", in_ready, !c && (exp_q.size() < 2));
    chk("kill_count", kill_count, k16);
    chk("kill_count_sat2", s_kill_count, k2);
  endtask

  initial begin
    logic          a;
    logic [PW-1:0] p;
    clr = 1'b1; in_valid = 1'b0; in_payload = '0; in_tid = '0;
    out_ready = 1'b0; kill_mask = '0;

    step(0, 0, 0, 1, 8'h00, 1, a);
    started = 1'b1;

    // streaming
    for (int i = 1; i <= 10; i++) step(1, PW'(i), 3'((i - 1) % 8), 1, 8'h00, 0, a);
    repeat (2) step(0, 0, 0, 1, 8'h00, 0, a);

    // backpressure with held input
    p = 101;
    for (int c = 0; c < 12; c++) begin
      step(1, p, p[2:0], (c < 2 || c >= 7), 8'h00, 0, a);
      if (a) p++;
    end
    repeat (3) step(0, 0, 0, 1, 8'h00, 0, a);

    // selective kill of the head, skid of another thread survives
    step(1, 200, 3, 0, 8'h00, 0, a);
    step(1, 201, 5, 0, 8'h00, 0, a);
    step(0, 0, 0, 0, 8'h08, 0, a);
    step(0, 0, 0, 1, 8'h00, 0, a);
    repeat (2) step(0, 0, 0, 1, 8'h00, 0, a);

    // kill stored head and incoming beat of the same thread
    step(1, 300, 2, 0, 8'h00, 0, a);
    step(1, 301, 2, 0, 8'h04, 0, a);
    step(0, 0, 0, 1, 8'h00, 0, a);

    // clear mid-operation with a beat offered during clr
    step(1, 400, 1, 0, 8'h00, 0, a);
    step(1, 401, 4, 0, 8'h00, 0, a);
    step(1, 402, 6, 1, 8'h00, 1, a);
    repeat (2) step(0, 0, 0, 1, 8'h00, 0, a);

    // drive the 2-bit counter into saturation
    for (int i = 0; i < 5; i++) step(1, PW'(500 + i), 7, 1, 8'h80, 0, a);
    step(0, 0, 0, 1, 8'h00, 0, a);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] km;
      km = ($urandom_range(0, 7) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 30) == 0) km = km | (8'h01 << $urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, PW'($urandom), 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, km, $urandom_range(0, 149) == 0, a);
    end
    repeat (4) step(0, 0, 0, 1, 8'h00, 0, a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
